// File: rtl/beat_seq_pkg.sv
// rtl/beat_seq_pkg.sv - shared types and defaults for the beat sequencer
package beat_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DEF_IBEAT_W      = 12;
    localparam int DEF_SONG_W       = 2;
    localparam int DEFAULT_SONG_LEN = 4095;

endpackage

// File: rtl/beat_step.sv
// rtl/beat_step.sv - boundary arithmetic for one beat step in either direction
module beat_step
    import beat_seq_pkg::*;
#(
    parameter int IBEAT_W = DEF_IBEAT_W
) (
    input  logic [IBEAT_W-1:0] ibeat,
    input  logic [IBEAT_W-1:0] eff_len,
    input  logic               rev,
    input  logic               loop_mode,
    output logic [IBEAT_W-1:0] next_ibeat,
    output logic               wrap_hit,
    output logic               end_hit
);

    localparam logic [IBEAT_W-1:0] ONE = IBEAT_W'(1);

    logic [IBEAT_W-1:0] last;

    always_comb begin
        last       = eff_len - ONE;
        next_ibeat = ibeat;
        wrap_hit   = 1'b0;
        end_hit    = 1'b0;
        if (!rev) begin
            if (ibeat < last) begin
                next_ibeat = ibeat + ONE;
            end else if (loop_mode) begin
                next_ibeat = '0;
                wrap_hit   = 1'b1;
            end else begin
                next_ibeat = last;
                end_hit    = 1'b1;
            end
        end else begin
            // A length that shrank under the counter snaps back to the new last beat.
            if (ibeat > last) begin
                next_ibeat = last;
            end else if (ibeat != '0) begin
                next_ibeat = ibeat - ONE;
            end else if (loop_mode) begin
                next_ibeat = last;
                wrap_hit   = 1'b1;
            end else begin
                next_ibeat = '0;
                end_hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/beat_sequencer.sv
// rtl/beat_sequencer.sv - beat index generator with pause, restart, song select and loop/once modes
module beat_sequencer
    import beat_seq_pkg::*;
#(
    parameter int IBEAT_W = DEF_IBEAT_W,
    parameter int SONG_W  = DEF_SONG_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               beat_en,
    input  logic               play_pause,
    input  logic               restart,
    input  logic               rev,
    input  logic               loop_mode,
    input  logic [SONG_W-1:0]  song_sel,
    input  logic [IBEAT_W-1:0] song_len,
    output logic [IBEAT_W-1:0] ibeat,
    output logic [SONG_W-1:0]  cur_song,
    output logic               playing,
    output logic               done,
    output logic               wrap,
    output logic               song_chg
);

    localparam logic [IBEAT_W-1:0] ONE = IBEAT_W'(1);

    state_e             state_q, state_d;
    logic [IBEAT_W-1:0] ibeat_q, ibeat_d;
    logic [SONG_W-1:0]  cur_song_q, cur_song_d;
    logic               playing_q, playing_d;
    logic               done_q, done_d;
    logic               wrap_q, wrap_d;
    logic               song_chg_q, song_chg_d;

    logic [IBEAT_W-1:0] eff_len;
    logic [IBEAT_W-1:0] last;
    logic [IBEAT_W-1:0] start;
    logic [IBEAT_W-1:0] next_ibeat;
    logic               wrap_hit;
    logic               end_hit;
    logic               chg;
    logic               jump;
    logic               step;

    assign eff_len = (song_len == '0) ? ONE : song_len;
    assign last    = eff_len - ONE;
    assign start   = rev ? last : '0;

    beat_step #(
        .IBEAT_W (IBEAT_W)
    ) u_beat_step (
        .ibeat      (ibeat_q),
        .eff_len    (eff_len),
        .rev        (rev),
        .loop_mode  (loop_mode),
        .next_ibeat (next_ibeat),
        .wrap_hit   (wrap_hit),
        .end_hit    (end_hit)
    );

    always_comb begin
        chg  = (song_sel != cur_song_q);
        jump = chg | restart;
        // A restart or song change owns ibeat this cycle; any coincident tick is dropped.
        step = (state_q == ST_RUN) & beat_en & play_pause & ~jump;

        ibeat_d    = ibeat_q;
        cur_song_d = cur_song_q;
        if (jump) begin
            ibeat_d = start;
        end else if (step) begin
            ibeat_d = next_ibeat;
        end
        if (chg) begin
            cur_song_d = song_sel;
        end

        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (play_pause) state_d = ST_RUN;
            ST_RUN: begin
                if (!play_pause)          state_d = ST_PAUSE;
                else if (step && end_hit) state_d = ST_DONE;
            end
            ST_PAUSE: if (play_pause) state_d = ST_RUN;
            ST_DONE:  if (jump) state_d = play_pause ? ST_RUN : ST_PAUSE;
            default:  state_d = ST_IDLE;
        endcase

        playing_d  = (state_d == ST_RUN);
        done_d     = (state_d == ST_DONE);
        wrap_d     = step & wrap_hit;
        song_chg_d = chg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ibeat_q    <= '0;
            cur_song_q <= '0;
            playing_q  <= 1'b0;
            done_q     <= 1'b0;
            wrap_q     <= 1'b0;
            song_chg_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ibeat_q    <= ibeat_d;
            cur_song_q <= cur_song_d;
            playing_q  <= playing_d;
            done_q     <= done_d;
            wrap_q     <= wrap_d;
            song_chg_q <= song_chg_d;
        end
    end

    assign ibeat    = ibeat_q;
    assign cur_song = cur_song_q;
    assign playing  = playing_q;
    assign done     = done_q;
    assign wrap     = wrap_q;
    assign song_chg = song_chg_q;

endmodule

// File: doc/beat_sequencer.md
Name: beat_sequencer

Overview:
Parametrised beat-index generator for the music player. It advances a beat counter once per beat tick and supports pause, restart, multiple songs, forward/reverse playback, and loop or play-once modes. The ibeat output addresses the note ROMs; status outputs drive the LEDs and the seven-segment display.

Parameters:
IBEAT_W, 12, width of the beat index and song length
SONG_W, 2, width of the song select (2**SONG_W songs)

Ports:
clk  in  1  system clock
reset_n  in  1  reset; one clock; reset is asynchronous and active-low
beat_en  in  1  one-cycle beat tick from the clock divider; it sets the playback rate
play_pause  in  1  level signal; 1 = play, 0 = pause
restart  in  1  one-cycle pulse; return to the start of the song
rev  in  1  level signal; 1 = count down, 0 = count up
loop_mode  in  1  level signal; 1 = wrap at the song end, 0 = stop at the song end
song_sel  in  SONG_W  requested song
song_len  in  IBEAT_W  beat count of the song on song_sel (from the song-length ROM, combinational)
ibeat  out  IBEAT_W  current beat index (registered)
cur_song  out  SONG_W  song currently playing (registered)
playing  out  1  1 while the state is RUN
done  out  1  1 while the state is DONE
wrap  out  1  one-cycle pulse when the counter wraps in loop mode
song_chg  out  1  one-cycle pulse when a song change is accepted

Behaviour:
- Reset values: ibeat=0, cur_song=0, state=IDLE, playing=0, done=0, wrap=0, song_chg=0.
- Effective length: eff_len = (song_len==0) ? 1 : song_len. Last beat: last = eff_len-1. This logic is combinational and is evaluated every cycle.
- Start point: start = rev ? last : 0.
- States: IDLE, RUN, PAUSE, DONE. playing = (state==RUN). done = (state==DONE). Both are registered.
- IDLE -> RUN when play_pause=1.
- RUN -> PAUSE when play_pause=0.
- PAUSE -> RUN when play_pause=1.
- RUN -> DONE on an end-of-song step in once mode.
- DONE -> RUN on restart or a song change when play_pause=1; otherwise DONE -> PAUSE.
- A step occurs only when state==RUN, beat_en=1, and play_pause=1 in that same cycle. The new ibeat is visible on the next clock edge (latency 1).
- Forward step (rev=0):
  - ibeat < last: ibeat+1.
  - ibeat >= last, loop_mode=1: ibeat=0 and wrap=1.
  - ibeat >= last, loop_mode=0: ibeat=last and the state goes to DONE.
- Reverse step (rev=1):
  - ibeat > last (length shrank): ibeat=last, with no wrap.
  - 0 < ibeat <= last: ibeat-1.
  - ibeat==0, loop_mode=1: ibeat=last and wrap=1.
  - ibeat==0, loop_mode=0: ibeat holds at 0 and the state goes to DONE.
- Arithmetic is modulo 2**IBEAT_W internally. With song_len=2**IBEAT_W-1, ibeat never exceeds 2**IBEAT_W-2.
- Song change: accepted in any cycle where song_sel != cur_song.
  - cur_song <= song_sel, ibeat <= start (computed from the new song_len), song_chg=1 for one cycle.
  - IDLE, RUN and PAUSE keep their state. DONE exits as described above.
  - After reset, a nonzero song_sel produces a song change on the first active cycle.
- Restart: ibeat <= start and DONE exits as described above. Other states are unchanged.
- Priority in one cycle: song change and restart (same ibeat result) > step. A step in a restart or song-change cycle is discarded. wrap is suppressed in that cycle.
- Toggling rev mid-song changes only the direction of later steps; ibeat is not moved. Toggling loop_mode while in DONE has no effect; leaving DONE needs restart or a song change.
- play_pause falling in the same cycle as beat_en: no step occurs, and the state goes to PAUSE.
- Asserting reset_n low mid-operation clears everything immediately (asynchronous). Release is synchronised externally.

Decomposition:
- Shared package beat_seq_pkg:
  - state enum (IDLE, RUN, PAUSE, DONE)
  - default IBEAT_W and SONG_W
  - DEFAULT_SONG_LEN = 4095
- One combinational sub-module, beat_step. Inputs: ibeat, eff_len, rev, loop_mode. Outputs: next_ibeat, wrap_hit, end_hit. This keeps the FSM separate from the boundary arithmetic and lets the two be verified independently.

Test Plan:
- Forward loop. song_len=4, loop_mode=1, play_pause=1, beat_en every 3rd cycle -> ibeat 0,1,2,3,0. wrap pulses for one cycle with the 3->0 update. playing=1.
- Once and reverse. song_len=5, rev=1, loop_mode=0, restart -> ibeat=4, then 3,2,1,0. done=1 and ibeat holds at 0 on further ticks. Then restart with play_pause=1 -> ibeat=4, state RUN.
- Pause. Drop play_pause at ibeat=7 in the same cycle as beat_en -> ibeat stays 7, playing=0. Ticks while paused do not move ibeat. Raise play_pause -> the next tick gives 8.
- Song change. Switch song_sel 0->2 mid-play with song_len=10 and rev=0 -> next cycle cur_song=2, ibeat=0, song_chg=1 for one cycle, state stays RUN. A simultaneous beat_en is discarded.
- Edge lengths. song_len=0 -> ibeat stays 0; a forward tick in loop mode gives wrap=1 each tick. Shrink song_len from 100 to 10 at ibeat=50 with rev=1 -> the next tick gives ibeat=9.
- Asynchronous reset. Pull reset_n low mid-count at ibeat=123 -> ibeat=0 and all outputs 0 without a clock edge; state IDLE after release.
